// File: rtl/count_bcd_display.sv
// rtl/count_bcd_display.sv - binary count to BCD (sequential double-dabble) with registered 7-segment digits
module count_bcd_display #(
  parameter int WIDTH          = 7,
  parameter bit BLANK_LZ       = 1'b1,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] count,
  output logic [6:0]       hex0,
  output logic [6:0]       hex1,
  output logic [6:0]       hex2,
  output logic [11:0]      bcd,
  output logic             busy,
  output logic             upd
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [3:0] LAST_ITER = 4'(WIDTH - 1);

  state_t                state, state_nx;
  logic [WIDTH-1:0]      count_q;
  logic [WIDTH-1:0]      last;
  logic [WIDTH-1:0]      shreg;
  logic [11:0]           scratch;
  logic [3:0]            iter;
  logic [11:0]           adj;
  logic [WIDTH+11:0]     shifted;
  logic                  blank2, blank1;

  // Table is written active-low; polarity is applied last so blank follows it too.
  function automatic logic [6:0] seg(input logic [3:0] d, input logic blank);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    if (blank) s = 7'b1111111;
    return SEG_ACTIVE_LOW ? s : ~s;
  endfunction

  always_comb begin
    adj = scratch;
    for (int n = 0; n < 3; n++) begin
      if (scratch[n*4 +: 4] >= 4'd5) adj[n*4 +: 4] = scratch[n*4 +: 4] + 4'd3;
    end
    shifted = {adj, shreg} << 1;
    blank2  = BLANK_LZ && (scratch[11:8] == 4'd0);
    blank1  = BLANK_LZ && (scratch[11:8] == 4'd0) && (scratch[7:4] == 4'd0);
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (count_q != last) state_nx = SHIFT;
      SHIFT:   if (iter == LAST_ITER) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
      last    <= '0;
      shreg   <= '0;
      scratch <= '0;
      iter    <= '0;
      bcd     <= '0;
      busy    <= 1'b0;
      upd     <= 1'b0;
      hex0    <= seg(4'd0, 1'b0);
      hex1    <= seg(4'd0, BLANK_LZ);
      hex2    <= seg(4'd0, BLANK_LZ);
    end else begin
      count_q <= count;
      upd     <= 1'b0;
      case (state)
        IDLE: begin
          if (count_q != last) begin
            shreg   <= count_q;
            last    <= count_q;
            scratch <= '0;
            iter    <= '0;
            busy    <= 1'b1;
          end
        end
        SHIFT: begin
          scratch <= shifted[WIDTH+11:WIDTH];
          shreg   <= shifted[WIDTH-1:0];
          iter    <= iter + 4'd1;
        end
        DONE: begin
          bcd  <= scratch;
          hex0 <= seg(scratch[3:0], 1'b0);
          hex1 <= seg(scratch[7:4], blank1);
          hex2 <= seg(scratch[11:8], blank2);
          upd  <= 1'b1;
          busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_count_bcd_display.sv
// tb/tb_count_bcd_display.sv - directed bench for count_bcd_display
module tb_count_bcd_display;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [6:0]  count = '0;
  logic [6:0]  hex0, hex1, hex2;
  logic [11:0] bcd;
  logic        busy, upd;
  logic [6:0]  nb_hex0, nb_hex1, nb_hex2;
  logic [11:0] nb_bcd;
  logic        nb_busy, nb_upd;

  int checks = 0;
  int failures = 0;
  int upd_cnt = 0;
  int busy_cnt = 0;
  int base_upd, base_busy;
  bit bad;

  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100;
  localparam logic [6:0] S5 = 7'b0010010, S7 = 7'b1111000, S8 = 7'b0000000;
  localparam logic [6:0] BL = 7'b1111111;

  count_bcd_display dut (
    .clk(clk), .rst(rst), .count(count),
    .hex0(hex0), .hex1(hex1), .hex2(hex2),
    .bcd(bcd), .busy(busy), .upd(upd)
  );

  count_bcd_display #(.BLANK_LZ(1'b0)) dut_nb (
    .clk(clk), .rst(rst), .count(count),
    .hex0(nb_hex0), .hex1(nb_hex1), .hex2(nb_hex2),
    .bcd(nb_bcd), .busy(nb_busy), .upd(nb_upd)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (upd)  upd_cnt++;
    if (busy) busy_cnt++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_upd(input string tag);
    bit found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (upd) begin
        found = 1'b1;
        break;
      end
    end
    chk(tag, 32'(found), 32'd1);
  endtask

  initial begin
    #2 rst = 1'b0;
    repeat (3) step();
    chk("rst_hex0", hex0, S0);
    chk("rst_hex1", hex1, BL);
    chk("rst_hex2", hex2, BL);
    chk("rst_bcd", bcd, 12'h000);
    chk("rst_busy_upd", {busy, upd}, 2'b00);
    chk("rst_nb_hex12", {nb_hex2, nb_hex1}, {S0, S0});

    rst = 1'b1;
    base_upd = upd_cnt;
    base_busy = busy_cnt;
    repeat (20) step();
    chk("idle_no_upd", upd_cnt - base_upd, 0);
    chk("idle_no_busy", busy_cnt - base_busy, 0);
    chk("idle_hex", {hex2, hex1, hex0}, {BL, BL, S0});

    // 0 -> 127 with exact latency
    count = 7'd127;
    step();
    chk("lat_busy_edge1", busy, 1'b0);
    step();
    chk("lat_busy_edge2", busy, 1'b1);
    bad = 1'b0;
    for (int i = 0; i < 7; i++) begin
      step();
      if (upd !== 1'b0 || busy !== 1'b1) bad = 1'b1;
    end
    chk("lat_shift_quiet", bad, 1'b0);
    step();
    chk("lat_upd_e8", upd, 1'b1);
    chk("lat_busy_e8", busy, 1'b0);
    chk("c127_bcd", bcd, 12'h127);
    chk("c127_hex", {hex2, hex1, hex0}, {S1, S2, S7});
    step();
    chk("c127_upd_fall", upd, 1'b0);

    count = 7'd5;
    wait_upd("c5_upd");
    chk("c5_bcd", bcd, 12'h005);
    chk("c5_hex", {hex2, hex1, hex0}, {BL, BL, S5});
    chk("c5_nb_hex", {nb_hex2, nb_hex1, nb_hex0}, {S0, S0, S5});

    count = 7'd100;
    wait_upd("c100_upd");
    chk("c100_bcd", bcd, 12'h100);
    chk("c100_hex", {hex2, hex1, hex0}, {S1, S0, S0});

    // change while busy: 9 -> 10 -> 11
    count = 7'd9;
    wait_upd("c9_upd");
    chk("c9_bcd", bcd, 12'h009);
    repeat (2) step();
    base_upd = upd_cnt;
    count = 7'd10;
    repeat (2) step();
    chk("c10_busy", busy, 1'b1);
    repeat (3) step();
    count = 7'd11;
    wait_upd("c10_upd");
    chk("c10_bcd", bcd, 12'h010);
    wait_upd("c11_upd");
    chk("c11_bcd", bcd, 12'h011);
    repeat (20) step();
    chk("c11_two_upd", upd_cnt - base_upd, 2);
    chk("c11_hold_bcd", bcd, 12'h011);

    // reset mid-conversion of 88
    count = 7'd88;
    repeat (2) step();
    repeat (3) step();
    chk("c88_busy_pre", busy, 1'b1);
    rst = 1'b0;
    #1;
    chk("mid_rst_bcd", bcd, 12'h000);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_hex", {hex2, hex1, hex0}, {BL, BL, S0});
    chk("mid_rst_nb_hex", {nb_hex2, nb_hex1, nb_hex0}, {S0, S0, S0});
    repeat (2) step();
    base_upd = upd_cnt;
    rst = 1'b1;
    wait_upd("c88_upd");
    chk("c88_bcd", bcd, 12'h088);
    chk("c88_hex", {hex2, hex1, hex0}, {BL, S8, S8});
    repeat (20) step();
    chk("c88_one_upd", upd_cnt - base_upd, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/count_bcd_display.md
Name: count_bcd_display

Overview:
Downstream consumer of the lab 7-bit up-counter's `count` bus. It converts the binary count to BCD with a sequential shift-add-3 (double-dabble) engine. It then drives three registered 7-segment digits (hundreds, tens, ones) for the board HEX displays. The block runs on the fast board clock and re-converts whenever the sampled count changes.

Parameters:
WIDTH, 7, bit width of input count; max value 2^WIDTH-1, must fit in 3 BCD digits (WIDTH <= 9)
BLANK_LZ, 1, 1 = blank leading-zero hundreds/tens digits; 0 = always show all three digits
SEG_ACTIVE_LOW, 1, 1 = segment lit when bit is 0 (board HEX); 0 = lit when 1

Ports:
clk  input  1  board clock; all state on posedge
rst  input  1  asynchronous, active-low reset
count  input  WIDTH  binary value from the counter
hex0  output  7  ones digit segments, bit order {g,f,e,d,c,b,a}
hex1  output  7  tens digit segments
hex2  output  7  hundreds digit segments
bcd  output  12  registered BCD result {hundreds,tens,ones}
busy  output  1  high while a conversion is in progress
upd  output  1  one-cycle pulse when the outputs take a new value

Behaviour:
- Async reset (rst=0), regardless of state:
  - state=IDLE; count_q=0; last=0; bcd=0; busy=0; upd=0.
  - hex0 = digit "0" (active-low 7'b1000000).
  - hex1/hex2 = blank (7'b1111111) if BLANK_LZ=1, else "0".
- Input stage: count_q <= count every clk. This is a single register to isolate the comparison from the slow-domain update edge.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - If count_q != last: at the edge, shreg <= count_q, last <= count_q, scratch BCD <= 0, iter <= 0, busy <= 1, go SHIFT.
  - Otherwise stay in IDLE.
- SHIFT, one iteration per clk:
  - Add 3 to each scratch nibble that is >= 5.
  - Shift {scratch,shreg} left by 1.
  - iter++.
  - Go to DONE after the iteration where iter == WIDTH-1 (WIDTH shifts total).
- DONE, at the edge:
  - bcd <= scratch.
  - hex0/1/2 <= decoded segments.
  - upd <= 1; busy <= 0; go IDLE.
- upd deasserts on the next edge.
- Latency: capture edge E0, shifts E1..E7 (WIDTH=7), outputs and upd registered at E8 (WIDTH+1 edges after capture).
- Outputs hold their value between updates; no glitching during conversion.
- Count change while busy: ignored until the FSM returns to IDLE. The next IDLE cycle sees count_q != last and starts a new conversion, so the final settled count is always displayed. Intermediate values may be skipped.
- Count unchanged: no conversion, no upd.
- Decoding:
  - Digits 0-9 use the standard 7-segment patterns (active-low values listed in the Test Plan). Nibble values 10-15 are unreachable; they decode to blank.
  - Blanking with BLANK_LZ=1:
    - hex2 blank when the hundreds digit is 0.
    - hex1 blank when both hundreds and tens are 0.
    - hex0 is never blank.
  - SEG_ACTIVE_LOW=0 inverts all segment outputs, including blank (all 0).
- Reset asserted mid-conversion: partial result discarded, outputs go to reset values immediately. Since last=0, a nonzero count after release triggers a fresh conversion.

Test Plan:
- Reset, count=0, release rst, wait 20 cycles:
  - hex0=7'b1000000, hex1=hex2=7'b1111111, bcd=12'h000.
  - upd never pulses, busy=0.
- count 0->127:
  - busy rises 2 edges after the change; upd pulses exactly 8 edges after the capture edge.
  - bcd=12'h127, hex2=7'b1111001 ("1"), hex1=7'b0100100 ("2"), hex0=7'b1111000 ("7").
- count=5:
  - bcd=12'h005, hex0=7'b0010010, hex1/hex2 blank.
  - Repeat with BLANK_LZ=0: hex1=hex2=7'b1000000.
- count=100:
  - hex2=7'b1111001, hex1=7'b1000000 (inner zero not blanked), hex0=7'b1000000.
- count 9->10 changed again to 11 three cycles into conversion:
  - First upd shows bcd=12'h010; a second conversion follows; the final bcd=12'h011.
  - Exactly two upd pulses.
- Pulse rst low during SHIFT of a conversion to 88:
  - Outputs immediately return to reset values.
  - After release with count=88 held: one conversion, bcd=12'h088, hex1=hex0=7'b0000000.
